// File: rtl/gold_descrambler.sv
// Complex Gold-code descrambler/scrambler: per accepted I/Q sample it derives a
// 2-bit chip from the X/Y LFSR pair and rotates the sample by R*90 degrees.
module gold_descrambler #(
  parameter int          DW          = 8,
  parameter int          MODE        = 0,
  parameter logic [17:0] SEED_X      = 18'h00001,
  parameter logic [17:0] SEED_Y      = 18'h3FFFF,
  parameter int          FRAME_LEN   = 38400,
  parameter int          AUTO_RESEED = 1,
  localparam int         CW          = $clog2(FRAME_LEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [2*DW-1:0] s_data,
  input  logic            s_sof,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [2*DW-1:0] m_data,
  output logic            m_sof,
  output logic [CW-1:0]   chip_idx
);

  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
  localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MOST_POS = {1'b0, {(DW-1){1'b1}}};

  function automatic logic [17:0] step_x(input logic [17:0] x);
    return {x[0] ^ x[7], x[17:1]};
  endfunction

  function automatic logic [17:0] step_y(input logic [17:0] y);
    return {y[10] ^ y[7] ^ y[5] ^ y[0], y[17:1]};
  endfunction

  function automatic logic [1:0] chips(input logic [17:0] x, input logic [17:0] y);
    logic z1, z2;
    z1 = x[0] ^ y[0];
    z2 = (x[4] ^ x[6] ^ x[15]) ^ (^{y[5], y[6], y[15:8]});
    return {z2, z1};
  endfunction

  // Negating the most negative value would overflow, so it clips to the most positive.
  function automatic logic [DW-1:0] sat_neg(input logic [DW-1:0] v);
    if (v == MOST_NEG) return MOST_POS;
    return ~v + {{(DW-1){1'b0}}, 1'b1};
  endfunction

  logic [17:0]     x_q, x_d, y_q, y_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            m_valid_q, m_valid_d;
  logic [2*DW-1:0] m_data_q, m_data_d;
  logic            m_sof_q, m_sof_d;
  logic [CW-1:0]   idx_q, idx_d;

  logic            accept;
  logic            frame_start;
  logic [CW-1:0]   idx_cur;
  logic [17:0]     x_eff, y_eff;
  logic [1:0]      r, r_rot;
  logic [DW-1:0]   i_in, q_in, i_out, q_out;

  assign s_ready = !rst && (!m_valid_q || m_ready);
  assign accept  = s_valid && s_ready;
  assign i_in    = s_data[2*DW-1:DW];
  assign q_in    = s_data[DW-1:0];

  // cnt_q is the index the next accepted sample will carry; 0 means a frame begins.
  assign frame_start = s_sof || ((AUTO_RESEED != 0) && (cnt_q == '0));
  assign idx_cur     = s_sof ? '0 : cnt_q;
  assign x_eff       = frame_start ? SEED_X : x_q;
  assign y_eff       = frame_start ? SEED_Y : y_q;
  assign r           = chips(x_eff, y_eff);
  // Scrambling uses the code itself rather than its conjugate: swap the +/-90 cases.
  assign r_rot       = (MODE != 0) ? {r[1] ^ r[0], r[0]} : r;

  always_comb begin
    i_out = i_in;
    q_out = q_in;
    case (r_rot)
      2'd1: begin
        i_out = q_in;
        q_out = sat_neg(i_in);
      end
      2'd2: begin
        i_out = sat_neg(i_in);
        q_out = sat_neg(q_in);
      end
      2'd3: begin
        i_out = sat_neg(q_in);
        q_out = i_in;
      end
      default: ;
    endcase
  end

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_sof_d   = m_sof_q;
    idx_d     = idx_q;
    if (accept) begin
      x_d       = step_x(x_eff);
      y_d       = step_y(y_eff);
      m_valid_d = 1'b1;
      m_data_d  = {i_out, q_out};
      m_sof_d   = frame_start;
      idx_d     = idx_cur;
      if (idx_cur == LAST_IDX)
        cnt_d = (AUTO_RESEED != 0) ? '0 : LAST_IDX;
      else
        cnt_d = idx_cur + CW'(1);
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= SEED_X;
      y_q       <= SEED_Y;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sof_q   <= 1'b0;
      idx_q     <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_sof_q   <= m_sof_d;
      idx_q     <= idx_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_sof    = m_sof_q;
  assign chip_idx = idx_q;

endmodule

// File: tb/tb_gold_descrambler.sv
// Directed bench for gold_descrambler: main instance (FRAME_LEN=4), a saturation
// instance (R=2 seeds, no auto reseed) and a scrambler->descrambler chain.
module tb_gold_descrambler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic        s_valid = 1'b0, s_sof = 1'b0, m_ready = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready, m_valid, m_sof;
  logic [15:0] m_data;
  logic [1:0]  chip_idx;

  logic        sat_s_valid = 1'b0, sat_s_sof = 1'b0, sat_m_ready = 1'b0;
  logic [15:0] sat_s_data = '0;
  logic        sat_s_ready, sat_m_valid, sat_m_sof;
  logic [15:0] sat_m_data;
  logic [0:0]  sat_chip_idx;

  logic        scr_s_valid = 1'b0, scr_s_sof = 1'b0, dsc_m_ready = 1'b1;
  logic [15:0] scr_s_data = '0;
  logic        scr_s_ready, scr_m_valid, scr_m_sof, dsc_s_ready, dsc_m_valid, dsc_m_sof;
  logic [15:0] scr_m_data, dsc_m_data;
  logic [1:0]  scr_chip_idx, dsc_chip_idx;

  int checks = 0;
  int errors = 0;

  gold_descrambler #(.DW(8), .MODE(0), .FRAME_LEN(4), .AUTO_RESEED(1)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sof(s_sof), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .chip_idx(chip_idx));

  gold_descrambler #(.DW(8), .MODE(0), .SEED_X(18'h00010), .SEED_Y(18'h00000),
                     .FRAME_LEN(2), .AUTO_RESEED(0)) u_sat (
    .clk(clk), .rst(rst), .s_valid(sat_s_valid), .s_ready(sat_s_ready), .s_data(sat_s_data),
    .s_sof(sat_s_sof), .m_valid(sat_m_valid), .m_ready(sat_m_ready), .m_data(sat_m_data),
    .m_sof(sat_m_sof), .chip_idx(sat_chip_idx));

  gold_descrambler #(.DW(8), .MODE(1), .FRAME_LEN(4), .AUTO_RESEED(1)) u_scr (
    .clk(clk), .rst(rst), .s_valid(scr_s_valid), .s_ready(scr_s_ready), .s_data(scr_s_data),
    .s_sof(scr_s_sof), .m_valid(scr_m_valid), .m_ready(dsc_s_ready), .m_data(scr_m_data),
    .m_sof(scr_m_sof), .chip_idx(scr_chip_idx));

  gold_descrambler #(.DW(8), .MODE(0), .FRAME_LEN(4), .AUTO_RESEED(1)) u_dsc (
    .clk(clk), .rst(rst), .s_valid(scr_m_valid), .s_ready(dsc_s_ready), .s_data(scr_m_data),
    .s_sof(scr_m_sof), .m_valid(dsc_m_valid), .m_ready(dsc_m_ready), .m_data(dsc_m_data),
    .m_sof(dsc_m_sof), .chip_idx(dsc_chip_idx));

  function automatic logic [15:0] iq(input int i, input int q);
    logic [7:0] a, b;
    a = i[7:0];
    b = q[7:0];
    return {a, b};
  endfunction

  task automatic test_reset();
    logic [20:0] got;
    rst = 1'b1; s_valid = 1'b1; s_sof = 1'b1; s_data = iq(1, 1); m_ready = 1'b0;
    sat_s_valid = 1'b1; scr_s_valid = 1'b1;
    repeat (3) @(negedge clk);
    got = {s_ready, m_valid, m_sof, chip_idx, m_data};
    checks++;
    if (got !== '0) begin errors++; $display("FAIL reset_main got %h want 0", got); end
    else $display("reset_main ok");
    checks++;
    if ({sat_s_ready, sat_m_valid, sat_m_data, scr_s_ready, dsc_m_valid} !== '0) begin
      errors++; $display("FAIL reset_other got %b want 0", {sat_s_ready, sat_m_valid, scr_s_ready, dsc_m_valid});
    end else $display("reset_other ok");
    rst = 1'b0; s_valid = 1'b0; s_sof = 1'b0; sat_s_valid = 1'b0; scr_s_valid = 1'b0; m_ready = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", s_ready); end
    else $display("ready_after_reset ok");
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset got %b want 0", m_valid); end
    else $display("idle_after_reset ok");
  endtask

  task automatic test_basic();
    int vi[3], vq[3];
    logic [15:0] ed[3];
    logic [19:0] got, exp;
    vi[0] = 10; vq[0] = 20;   ed[0] = iq(10, 20);
    vi[1] = 10; vq[1] = 20;   ed[1] = iq(20, -10);
    vi[2] = 5;  vq[2] = -128; ed[2] = iq(-128, -5);
    m_ready = 1'b1; s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_sof = (k == 0);
      s_data = iq(vi[k], vq[k]);
      @(negedge clk);
      got = {m_valid, m_sof, chip_idx, m_data};
      exp = {1'b1, k == 0, 2'(k), ed[k]};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL basic_%0d got %h want %h", k, got, exp); end
      else $display("basic_%0d ok data=%h", k, m_data);
    end
    s_valid = 1'b0; s_sof = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", m_valid); end
    else $display("basic_drain ok");
  endtask

  task automatic test_back_to_back();
    logic [19:0] got, exp;
    int vi[4], vq[4];
    logic [15:0] ed[4];
    vi[0] = 3; vq[0] = 4;  ed[0] = iq(4, -3);
    vi[1] = 5; vq[1] = 6;  ed[1] = iq(6, -5);
    vi[2] = 7; vq[2] = 8;  ed[2] = iq(8, -7);
    vi[3] = 9; vq[3] = 10; ed[3] = iq(9, 10);
    s_valid = 1'b1; s_sof = 1'b1; s_data = iq(1, 2); m_ready = 1'b0;
    @(negedge clk);
    s_sof = 1'b0; s_data = iq(vi[0], vq[0]);
    exp = {1'b1, 1'b1, 2'd0, iq(1, 2)};
    for (int c = 0; c < 5; c++) begin
      got = {m_valid, m_sof, chip_idx, m_data};
      checks++;
      if (got !== exp || s_ready !== 1'b0) begin
        errors++; $display("FAIL stall_%0d got %h ready %b want %h ready 0", c, got, s_ready, exp);
      end else $display("stall_%0d ok", c);
      @(negedge clk);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      got = {m_valid, m_sof, chip_idx, m_data};
      exp = {1'b1, k == 3, 2'((k + 1) % 4), ed[k]};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL resume_%0d got %h want %h", k, got, exp); end
      else $display("resume_%0d ok data=%h", k, m_data);
      if (k < 3) s_data = iq(vi[k + 1], vq[k + 1]);
    end
    s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [18:0] got, exp;
    int vi[4], vq[4];
    logic vs[4], es[4], ei[4];
    logic [15:0] ed[4];
    vs[0] = 1; vi[0] = -128; vq[0] = -128; es[0] = 1; ei[0] = 0; ed[0] = iq(127, 127);
    vs[1] = 0; vi[1] = 3;    vq[1] = -4;   es[1] = 0; ei[1] = 1; ed[1] = iq(3, -4);
    vs[2] = 0; vi[2] = 7;    vq[2] = 8;    es[2] = 0; ei[2] = 1; ed[2] = iq(7, 8);
    vs[3] = 1; vi[3] = 5;    vq[3] = -128; es[3] = 1; ei[3] = 0; ed[3] = iq(-5, 127);
    sat_m_ready = 1'b1; sat_s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sat_s_sof = vs[k];
      sat_s_data = iq(vi[k], vq[k]);
      @(negedge clk);
      got = {sat_m_valid, sat_m_sof, sat_chip_idx, sat_m_data};
      exp = {1'b1, es[k], ei[k], ed[k]};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL sat_%0d got %h want %h", k, got, exp); end
      else $display("sat_%0d ok data=%h", k, sat_m_data);
    end
    sat_s_valid = 1'b0; sat_s_sof = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_auto_reseed();
    logic [19:0] got, exp;
    logic [15:0] ed;
    int ph;
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      s_valid = 1'b1;
      s_data = iq(k + 1, 2 * k + 3);
      @(negedge clk);
      ph = k % 4;
      ed = (ph == 0) ? iq(k + 1, 2 * k + 3) : iq(2 * k + 3, -(k + 1));
      exp = {1'b1, ph == 0, 2'(ph), ed};
      got = {m_valid, m_sof, chip_idx, m_data};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reseed_%0d got %h want %h", k, got, exp); end
      else $display("reseed_%0d ok idx=%0d data=%h", k, chip_idx, m_data);
    end
    s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_midstream();
    logic [19:0] got, exp;
    logic tv[6], ts[6], es[6];
    int ti[6], tq[6], ex[6];
    logic [15:0] ed[6];
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_sof = (k == 0);
      s_data = iq(11 + 2 * k, 12 + 2 * k);
      @(negedge clk);
      got = {m_valid, m_sof, chip_idx, m_data};
      exp = {1'b1, k == 0, 2'(k), (k == 0) ? iq(11, 12) : iq(12 + 2 * k, -(11 + 2 * k))};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL pre_rst_%0d got %h want %h", k, got, exp); end
      else $display("pre_rst_%0d ok data=%h", k, m_data);
    end
    rst = 1'b1; s_sof = 1'b0; s_data = iq(17, 18);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rst got valid %b ready %b want 0 0", m_valid, s_ready);
    end else $display("mid_rst ok");
    rst = 1'b0;
    tv[0] = 1; ts[0] = 0; ti[0] = 21; tq[0] = 22; es[0] = 1; ex[0] = 0; ed[0] = iq(21, 22);
    tv[1] = 1; ts[1] = 0; ti[1] = 23; tq[1] = 24; es[1] = 0; ex[1] = 1; ed[1] = iq(24, -23);
    tv[2] = 0; ts[2] = 1; ti[2] = 0;  tq[2] = 0;  es[2] = 0; ex[2] = 0; ed[2] = '0;
    tv[3] = 1; ts[3] = 0; ti[3] = 25; tq[3] = 26; es[3] = 0; ex[3] = 2; ed[3] = iq(26, -25);
    tv[4] = 1; ts[4] = 1; ti[4] = 27; tq[4] = 28; es[4] = 1; ex[4] = 0; ed[4] = iq(27, 28);
    tv[5] = 1; ts[5] = 0; ti[5] = 29; tq[5] = 30; es[5] = 0; ex[5] = 1; ed[5] = iq(30, -29);
    for (int k = 0; k < 6; k++) begin
      s_valid = tv[k]; s_sof = ts[k]; s_data = iq(ti[k], tq[k]);
      @(negedge clk);
      checks++;
      if (tv[k]) begin
        got = {m_valid, m_sof, chip_idx, m_data};
        exp = {1'b1, es[k], 2'(ex[k]), ed[k]};
        if (got !== exp) begin errors++; $display("FAIL post_rst_%0d got %h want %h", k, got, exp); end
        else $display("post_rst_%0d ok data=%h", k, m_data);
      end else begin
        if (m_valid !== 1'b0) begin errors++; $display("FAIL post_rst_%0d got valid %b want 0", k, m_valid); end
        else $display("post_rst_%0d idle ok", k);
      end
    end
    s_valid = 1'b0; s_sof = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_trip();
    logic [19:0] got, exp;
    int ri[6], rq[6];
    logic [15:0] es[6], ed[6];
    ri[0] = 1;   rq[0] = 2;    es[0] = iq(1, 2);      ed[0] = iq(1, 2);
    ri[1] = 3;   rq[1] = 4;    es[1] = iq(-4, 3);     ed[1] = iq(3, 4);
    ri[2] = 4;   rq[2] = -128; es[2] = iq(127, 4);    ed[2] = iq(4, -127);
    ri[3] = -7;  rq[3] = 9;    es[3] = iq(-9, -7);    ed[3] = iq(-7, 9);
    ri[4] = 100; rq[4] = -100; es[4] = iq(100, -100); ed[4] = iq(100, -100);
    ri[5] = -50; rq[5] = 60;   es[5] = iq(-60, -50);  ed[5] = iq(-50, 60);
    dsc_m_ready = 1'b1;
    scr_s_valid = 1'b1; scr_s_sof = 1'b1; scr_s_data = iq(ri[0], rq[0]);
    for (int p = 0; p < 7; p++) begin
      @(negedge clk);
      if (p < 6) begin
        got = {scr_m_valid, scr_m_sof, scr_chip_idx, scr_m_data};
        exp = {1'b1, (p % 4) == 0, 2'(p % 4), es[p]};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL scramble_%0d got %h want %h", p, got, exp); end
        else $display("scramble_%0d ok data=%h", p, scr_m_data);
      end
      if (p >= 1) begin
        got = {dsc_m_valid, dsc_m_sof, dsc_chip_idx, dsc_m_data};
        exp = {1'b1, ((p - 1) % 4) == 0, 2'((p - 1) % 4), ed[p - 1]};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL roundtrip_%0d got %h want %h", p - 1, got, exp); end
        else $display("roundtrip_%0d ok data=%h", p - 1, dsc_m_data);
      end
      scr_s_sof = 1'b0;
      if (p < 5) scr_s_data = iq(ri[p + 1], rq[p + 1]);
      else scr_s_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_auto_reseed();
    test_midstream();
    test_round_trip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
